// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - sequencer control/handshake bundle between the FSM and the datapath/memories
interface multicycle_ctrl_fsm_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic [31:0]      inst;
   logic             imem_ack;
   logic             dmem_ack;
   logic             alu_zero;
   logic             imem_req;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [2:0]       alu_ctrl;
   logic             dmem_req;
   logic             dmem_we;
   logic             reg_write;
   logic             wb_sel;
   logic             trap;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   modport master (
      input  run, inst, imem_ack, dmem_ack, alu_zero,
      output imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl,
             dmem_req, dmem_we, reg_write, wb_sel, trap, state, instret
   );

   modport slave (
      output run, inst, imem_ack, dmem_ack, alu_zero,
      input  imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl,
             dmem_req, dmem_we, reg_write, wb_sel, trap, state, instret
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter
module multicycle_ctrl_fsm #(
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   multicycle_ctrl_fsm_if.master bus
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_OP     = 7'h33;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             retire;
   logic             legal_op;
   logic             taken;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             unused_inst_bits;

   assign opcode           = bus.inst[6:0];
   assign funct3           = bus.inst[14:12];
   assign unused_inst_bits = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7]};

   always_comb begin
      legal_op = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
         OP_LOAD, OP_STORE, OP_IMM, OP_OP: legal_op = 1'b1;
         default:                          legal_op = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instret_q <= instret_q + 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      taken         = 1'b0;
      bus.imem_req  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_src    = 2'd0;
      bus.alu_src_a = 2'd0;
      bus.alu_src_b = 2'd0;
      bus.alu_ctrl  = ALU_AND;
      bus.dmem_req  = 1'b0;
      bus.dmem_we   = 1'b0;
      bus.reg_write = 1'b0;
      bus.wb_sel    = 1'b0;
      bus.trap      = 1'b0;
      case (state_q)
         FETCH: begin
            // ack arriving while run is low is dropped, not remembered
            bus.imem_req = bus.run;
            if (bus.run && bus.imem_ack) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_d      = DECODE;
            end
         end
         DECODE: state_d = legal_op ? EXEC : TRAP;
         EXEC: begin
            case (opcode)
               OP_LUI: begin
                  bus.alu_src_a = 2'd2;
                  bus.alu_src_b = 2'd1;
                  bus.alu_ctrl  = ALU_ADD;
                  state_d       = WB;
               end
               OP_AUIPC: begin
                  bus.alu_src_a = 2'd1;
                  bus.alu_src_b = 2'd1;
                  bus.alu_ctrl  = ALU_ADD;
                  state_d       = WB;
               end
               OP_OP, OP_IMM: begin
                  bus.alu_src_b = (opcode == OP_OP) ? 2'd0 : 2'd1;
                  state_d       = WB;
                  case (funct3)
                     3'b000:  bus.alu_ctrl = (opcode == OP_OP && bus.inst[30]) ? ALU_SUB : ALU_ADD;
                     3'b010:  bus.alu_ctrl = ALU_SLT;
                     3'b110:  bus.alu_ctrl = ALU_OR;
                     3'b111:  bus.alu_ctrl = ALU_AND;
                     default: state_d      = TRAP;
                  endcase
               end
               OP_BRANCH: begin
                  bus.alu_ctrl = ALU_SUB;
                  case (funct3)
                     3'b000: begin taken = bus.alu_zero;  retire = 1'b1; state_d = FETCH; end
                     3'b001: begin taken = !bus.alu_zero; retire = 1'b1; state_d = FETCH; end
                     default: state_d = TRAP;
                  endcase
                  bus.pc_write = taken;
                  bus.pc_src   = taken ? 2'd1 : 2'd0;
               end
               OP_JAL: begin
                  // link value is computed here while the PC is redirected
                  bus.pc_write  = 1'b1;
                  bus.pc_src    = 2'd1;
                  bus.alu_src_a = 2'd1;
                  bus.alu_src_b = 2'd2;
                  bus.alu_ctrl  = ALU_ADD;
                  state_d       = WB;
               end
               OP_JALR: begin
                  bus.pc_write  = 1'b1;
                  bus.pc_src    = 2'd2;
                  bus.alu_src_b = 2'd1;
                  bus.alu_ctrl  = ALU_ADD;
                  state_d       = WB;
               end
               OP_LOAD, OP_STORE: begin
                  bus.alu_src_b = 2'd1;
                  bus.alu_ctrl  = ALU_ADD;
                  state_d       = MEM;
               end
               default: state_d = TRAP;
            endcase
         end
         MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = (opcode == OP_STORE);
            if (bus.dmem_ack) begin
               if (opcode == OP_STORE) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end
         end
         WB: begin
            bus.reg_write = 1'b1;
            bus.wb_sel    = (opcode == OP_LOAD);
            retire        = 1'b1;
            state_d       = FETCH;
         end
         TRAP:    bus.trap = 1'b1;
         default: state_d  = FETCH;
      endcase
   end

   assign bus.state   = state_q;
   assign bus.instret = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed bench for the sequencer with a write-back scoreboard
module tb_multicycle_ctrl_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic sb[$];

   always #5 clk = ~clk;

   multicycle_ctrl_fsm_if #(.CNT_W(32)) bus ();

   multicycle_ctrl_fsm #(.CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Issues a fetch with an immediate ack and leaves the bench at the DECODE sample point.
   task automatic fetch(input logic [31:0] i);
      bus.inst     = i;
      bus.run      = 1'b1;
      bus.imem_ack = 1'b1;
      #1;
      check("fetch_state", 32'(bus.state), 32'd0);
      check("fetch_imem_req", 32'(bus.imem_req), 32'd1);
      check("fetch_ir_write", 32'(bus.ir_write), 32'd1);
      check("fetch_pc_write", 32'(bus.pc_write), 32'd1);
      check("fetch_pc_src", 32'(bus.pc_src), 32'd0);
      @(negedge clk);
      bus.imem_ack = 1'b0;
      check("decode_state", 32'(bus.state), 32'd1);
   endtask

   // Every write-back strobe must match the next expected write-back source.
   always @(negedge clk) begin
      if (!rst && bus.reg_write) begin
         check("sb_underflow", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) check("sb_wb_sel", 32'(bus.wb_sel), 32'(sb.pop_front()));
      end
   end

   task automatic branch(input logic zero, input logic [31:0] exp_instret);
      bus.alu_zero = zero;
      fetch(32'h80000063);
      tick();
      check("beq_exec_state", 32'(bus.state), 32'd2);
      check("beq_alu_ctrl", 32'(bus.alu_ctrl), 32'd6);
      check("beq_pc_write", 32'(bus.pc_write), 32'(zero));
      check("beq_pc_src", 32'(bus.pc_src), zero ? 32'd1 : 32'd0);
      check("beq_reg_write", 32'(bus.reg_write), 32'd0);
      tick();
      check("beq_back_fetch", 32'(bus.state), 32'd0);
      check("beq_instret", bus.instret, exp_instret);
   endtask

   initial begin
      bus.run      = 1'b0;
      bus.inst     = 32'h0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      bus.alu_zero = 1'b0;
      repeat (2) tick();
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_instret", bus.instret, 32'd0);
      check("rst_trap", 32'(bus.trap), 32'd0);
      check("rst_imem_req", 32'(bus.imem_req), 32'd0);
      check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      check("rst_reg_write", 32'(bus.reg_write), 32'd0);
      rst = 1'b0;

      // addi x1,x0,10
      sb.push_back(1'b0);
      fetch(32'h00A00093);
      tick();
      check("addi_exec_state", 32'(bus.state), 32'd2);
      check("addi_alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
      check("addi_src_a", 32'(bus.alu_src_a), 32'd0);
      check("addi_src_b", 32'(bus.alu_src_b), 32'd1);
      tick();
      check("addi_wb_state", 32'(bus.state), 32'd4);
      tick();
      check("addi_fetch_state", 32'(bus.state), 32'd0);
      check("addi_reg_write_off", 32'(bus.reg_write), 32'd0);
      check("addi_instret", bus.instret, 32'd1);

      // beq taken then not taken
      branch(1'b1, 32'd2);
      branch(1'b0, 32'd3);

      // lb with dmem_ack three cycles late
      sb.push_back(1'b1);
      fetch(32'h80000003);
      tick();
      check("lb_alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
      check("lb_src_b", 32'(bus.alu_src_b), 32'd1);
      tick();
      for (int k = 0; k < 4; k++) begin
         check("lb_mem_state", 32'(bus.state), 32'd3);
         check("lb_dmem_req", 32'(bus.dmem_req), 32'd1);
         check("lb_dmem_we", 32'(bus.dmem_we), 32'd0);
         if (k == 3) bus.dmem_ack = 1'b1;
         tick();
      end
      bus.dmem_ack = 1'b0;
      check("lb_wb_state", 32'(bus.state), 32'd4);
      check("lb_wb_sel", 32'(bus.wb_sel), 32'd1);
      tick();
      check("lb_instret", bus.instret, 32'd4);

      // illegal opcode
      fetch(32'h00000000);
      tick();
      check("trap_state", 32'(bus.state), 32'd5);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("trap_sticky", 32'(bus.trap), 32'd1);
         check("trap_no_req", 32'(bus.imem_req), 32'd0);
         check("trap_instret", bus.instret, 32'd4);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("trap_rst_trap", 32'(bus.trap), 32'd0);
      check("trap_rst_state", 32'(bus.state), 32'd0);
      check("trap_rst_instret", bus.instret, 32'd0);

      // reset during the MEM phase of a store
      sb.push_back(1'b0);
      fetch(32'h00A00093);
      tick();
      tick();
      tick();
      check("pre_sw_instret", bus.instret, 32'd1);
      fetch(32'h00112023);
      tick();
      tick();
      check("sw_mem_state", 32'(bus.state), 32'd3);
      check("sw_dmem_req", 32'(bus.dmem_req), 32'd1);
      check("sw_dmem_we", 32'(bus.dmem_we), 32'd1);
      rst = 1'b1;
      tick();
      check("sw_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      check("sw_rst_state", 32'(bus.state), 32'd0);
      check("sw_rst_instret", bus.instret, 32'd0);
      rst = 1'b0;

      // run low in FETCH with imem_ack toggling, then jal
      bus.run = 1'b0;
      for (int k = 0; k < 10; k++) begin
         bus.imem_ack = (k % 2 == 0);
         #1;
         check("idle_ir_write", 32'(bus.ir_write), 32'd0);
         check("idle_pc_write", 32'(bus.pc_write), 32'd0);
         check("idle_imem_req", 32'(bus.imem_req), 32'd0);
         tick();
         check("idle_state", 32'(bus.state), 32'd0);
      end
      bus.imem_ack = 1'b0;
      sb.push_back(1'b0);
      fetch(32'h8020006F);
      tick();
      check("jal_exec_state", 32'(bus.state), 32'd2);
      check("jal_pc_write", 32'(bus.pc_write), 32'd1);
      check("jal_pc_src", 32'(bus.pc_src), 32'd1);
      tick();
      check("jal_wb_state", 32'(bus.state), 32'd4);
      check("jal_reg_write", 32'(bus.reg_write), 32'd1);
      tick();
      check("jal_instret", bus.instret, 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
